// File: rtl/atm_card_mem_arbiter.sv
// atm_card_mem_arbiter
//   Round-robin arbiter and sequencer for the single-port card-data RAM.
//   Three requesters (0 session, 1 poster, 2 logger) issue READ, WRITE, ADD
//   or SUB. ADD/SUB run as an uninterrupted read-modify-write, so
//   concurrent balance postings are serialised and never lose updates.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid[2:0]           per-requester request, held until rsp_valid
//   req_op/addr/wdata        packed per-requester operands {r2,r1,r0}
//   gnt[2:0], busy           one-hot current owner, sequencer not idle
//   rsp_valid/rdata/err      one-cycle completion pulse, result, error code
//   mem_en/we/addr/wdata     RAM command; mem_rdata returns one cycle later
module atm_card_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_valid,
  input  logic [5:0]            req_op,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic                  busy,
  output logic [2:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [7:0]            rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RDWAIT,
    S_WB,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_SUB   = 2'b11
  } op_t;

  localparam logic [7:0] ERR_NONE  = 8'h00;
  localparam logic [7:0] ERR_FUNDS = 8'h03;
  localparam logic [7:0] ERR_OVF   = 8'h05;

  state_t              state, state_nxt;
  logic [1:0]          ptr;
  logic [1:0]          owner;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;   // response data, also the WB value
  logic [7:0]          err_q;
  logic [2:0]          owner_oh;

  // Round-robin winner: first requesting index starting at ptr.
  logic [1:0]          win;
  logic                found;
  logic [1:0]          cand;

  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  // RMW arithmetic on the word returned during RDWAIT.
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   diff;
  logic                add_ovf;
  logic                sub_short;

  always_comb begin
    sum       = {1'b0, mem_rdata} + {1'b0, wdata_q};
    diff      = mem_rdata - wdata_q;
    add_ovf   = sum[DATA_W];
    sub_short = (wdata_q > mem_rdata);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (found) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = (op_q == OP_WRITE) ? S_RESP : S_RDWAIT;
      S_RDWAIT: begin
        unique case (op_q)
          OP_ADD:  state_nxt = add_ovf   ? S_RESP : S_WB;
          OP_SUB:  state_nxt = sub_short ? S_RESP : S_WB;
          default: state_nxt = S_RESP;
        endcase
      end
      S_WB:     state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs. Memory strobes and the response pulse are gated by rst so an
  // operation interrupted by reset never commits its write-back or responds.
  always_comb begin
    owner_oh  = 3'b001 << owner;
    busy      = (state != S_IDLE);
    gnt       = busy ? owner_oh : '0;
    rsp_valid = (state == S_RESP && !rst) ? owner_oh : '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == S_ACCESS) begin
      mem_en    = !rst;
      mem_we    = !rst && (op_q == OP_WRITE);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end else if (state == S_WB) begin
      mem_en    = !rst;
      mem_we    = !rst;
      mem_addr  = addr_q;
      mem_wdata = rdata_q;
    end
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Operand latch, result datapath and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 2'd0;
      owner   <= 2'd0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            owner   <= win;
            op_q    <= op_t'(req_op[2*win +: 2]);
            addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[win*DATA_W +: DATA_W];
            err_q   <= ERR_NONE;
          end
        end
        S_ACCESS: begin
          if (op_q == OP_WRITE) rdata_q <= wdata_q;
        end
        S_RDWAIT: begin
          unique case (op_q)
            OP_ADD: begin
              if (add_ovf) begin
                err_q   <= ERR_OVF;
                rdata_q <= mem_rdata;
              end else begin
                rdata_q <= sum[DATA_W-1:0];
              end
            end
            OP_SUB: begin
              if (sub_short) begin
                err_q   <= ERR_FUNDS;
                rdata_q <= mem_rdata;
              end else begin
                rdata_q <= diff;
              end
            end
            default: rdata_q <= mem_rdata;
          endcase
        end
        S_RESP: ptr <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_card_mem_arbiter.sv
module tb_atm_card_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [5:0]  req_op;
  logic [29:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  gnt;
  logic        busy;
  logic [2:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic [7:0]  rsp_err;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int mptr     = 0;

  always #5 clk = ~clk;

  atm_card_mem_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Card-data RAM environment with a preload port for the bench.
  logic [15:0] ram [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference behaviour of one operation on an old memory word.
  function automatic void model(input logic [1:0] op, input logic [15:0] old,
                                input logic [15:0] wd, output logic [15:0] rd,
                                output logic [7:0] er, output logic [15:0] nv,
                                output int lat, output int wr);
    int s;
    nv = old; er = 8'h00; wr = 0; rd = old; lat = 3;
    case (op)
      2'd0: begin rd = old; lat = 3; end
      2'd1: begin rd = wd; nv = wd; lat = 2; wr = 1; end
      2'd2: begin
        s = int'(old) + int'(wd);
        if (s > 65535) begin er = 8'h05; rd = old; lat = 3; end
        else begin rd = s[15:0]; nv = rd; lat = 4; wr = 1; end
      end
      default: begin
        if (wd > old) begin er = 8'h03; rd = old; lat = 3; end
        else begin rd = old - wd; nv = rd; lat = 4; wr = 1; end
      end
    endcase
  endfunction

  function automatic int pick(input logic [2:0] pend, input int p);
    for (int k = 0; k < 3; k++)
      if (pend[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d; ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; mptr = 0;
  endtask

  // Issue one request alone and record what the DUT does until its response.
  // Operands are scrambled right after acceptance to expose missing latching.
  task automatic run_op(input int r, input logic [1:0] op, input logic [9:0] a,
                        input logic [15:0] wd, output int lat,
                        output logic [15:0] rd, output logic [7:0] er,
                        output logic [2:0] g, output logic [2:0] rv,
                        output int wr_cnt, output logic [15:0] wr_data,
                        output logic [9:0] wr_addr);
    rd = '0; er = '0; g = '0; rv = '0; wr_cnt = 0; wr_data = '0; wr_addr = '0;
    @(negedge clk);
    req_op[r*2 +: 2] = op; req_addr[r*10 +: 10] = a; req_wdata[r*16 +: 16] = wd;
    req_valid[r] = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        g = gnt;
        req_addr[r*10 +: 10] = ~a; req_wdata[r*16 +: 16] = ~wd;
        req_op[r*2 +: 2] = ~op;
      end
      if (mem_we) begin wr_cnt++; wr_data = mem_wdata; wr_addr = mem_addr; end
      if (rsp_valid != 3'b000) begin
        rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); end
    n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_strobes got en=%b we=%b want 0 0", mem_en, mem_we); end
    rst = 1'b0; mptr = 0;
    @(negedge clk);
    n_checks++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0000", rsp_rdata); end
    n_checks++; if (rsp_err !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_err got %h want 00", rsp_err); end
    n_checks++; if (mem_addr !== 10'h000 || mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_bus got addr=%h wdata=%h want 000 0000", mem_addr, mem_wdata); end
    n_checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin n_fail++; $display("FAIL reset_idle got busy=%b gnt=%b want 0 000", busy, gnt); end
  endtask

  typedef struct {
    int          r;
    logic [1:0]  op;
    logic [9:0]  a;
    logic [15:0] wd;
    bit          pre;
    logic [15:0] pv;
  } vec_t;

  task automatic test_single_ops();
    vec_t tbl[10];
    int lat, elat, ewr, wr_cnt;
    logic [15:0] rd, erd, env, wr_data;
    logic [7:0]  er, eer;
    logic [2:0]  g, rv, oh;
    logic [9:0]  wr_addr;
    tbl[0] = '{0, 2'd0, 10'h005, 16'h0000, 1'b1, 16'h1234};
    tbl[1] = '{1, 2'd3, 10'h010, 16'h0064, 1'b1, 16'h03E8};
    tbl[2] = '{1, 2'd3, 10'h010, 16'h0400, 1'b0, 16'h0000};
    tbl[3] = '{1, 2'd2, 10'h011, 16'h0001, 1'b1, 16'hFFFF};
    tbl[4] = '{1, 2'd2, 10'h012, 16'h0001, 1'b1, 16'hFFFE};
    tbl[5] = '{2, 2'd3, 10'h013, 16'h0050, 1'b1, 16'h0050};
    tbl[6] = '{2, 2'd1, 10'h3FF, 16'hBEEF, 1'b0, 16'h0000};
    tbl[7] = '{0, 2'd0, 10'h3FF, 16'h0000, 1'b0, 16'h0000};
    tbl[8] = '{0, 2'd2, 10'h000, 16'h7FFF, 1'b1, 16'h8000};
    tbl[9] = '{1, 2'd3, 10'h011, 16'hFFFF, 1'b0, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].pre) poke(tbl[i].a, tbl[i].pv);
      model(tbl[i].op, ref_mem[tbl[i].a], tbl[i].wd, erd, eer, env, elat, ewr);
      run_op(tbl[i].r, tbl[i].op, tbl[i].a, tbl[i].wd, lat, rd, er, g, rv, wr_cnt, wr_data, wr_addr);
      ref_mem[tbl[i].a] = env;
      oh = 3'b001 << tbl[i].r;
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL op%0d_latency got %0d want %0d", i, lat, elat); end
      n_checks++; if (g !== oh) begin n_fail++; $display("FAIL op%0d_gnt got %b want %b", i, g, oh); end
      n_checks++; if (rv !== oh) begin n_fail++; $display("FAIL op%0d_rsp_valid got %b want %b", i, rv, oh); end
      n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL op%0d_rdata got %h want %h", i, rd, erd); end
      n_checks++; if (er !== eer) begin n_fail++; $display("FAIL op%0d_err got %h want %h", i, er, eer); end
      n_checks++; if (wr_cnt !== ewr) begin n_fail++; $display("FAIL op%0d_write_count got %0d want %0d", i, wr_cnt, ewr); end
      if (ewr == 1) begin
        n_checks++; if (wr_data !== env || wr_addr !== tbl[i].a) begin n_fail++; $display("FAIL op%0d_write_bus got %h@%h want %h@%h", i, wr_data, wr_addr, env, tbl[i].a); end
      end
      n_checks++; if (ram[tbl[i].a] !== ref_mem[tbl[i].a]) begin n_fail++; $display("FAIL op%0d_memory got %h want %h", i, ram[tbl[i].a], ref_mem[tbl[i].a]); end
      mptr = (tbl[i].r + 1) % 3;
    end
  endtask

  task automatic test_round_robin();
    int n, cyc, last, exp_r;
    logic [9:0] ad[3];
    logic [2:0] oh;
    ad[0] = 10'h005; ad[1] = 10'h010; ad[2] = 10'h3FF;
    do_reset();
    @(negedge clk);
    req_op = '0;
    req_addr = {ad[2], ad[1], ad[0]};
    req_valid = 3'b111;
    n = 0; cyc = 0; last = -1;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != 3'b000) begin
        exp_r = n % 3;
        oh = 3'b001 << exp_r;
        n_checks++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL rr%0d_rsp_valid got %b want %b", n, rsp_valid, oh); end
        n_checks++; if (gnt !== oh) begin n_fail++; $display("FAIL rr%0d_gnt got %b want %b", n, gnt, oh); end
        n_checks++; if (rsp_rdata !== ref_mem[ad[exp_r]]) begin n_fail++; $display("FAIL rr%0d_rdata got %h want %h", n, rsp_rdata, ref_mem[ad[exp_r]]); end
        n_checks++; if (cyc !== ((last < 0) ? 3 : last + 4)) begin n_fail++; $display("FAIL rr%0d_spacing got cycle %0d want %0d", n, cyc, (last < 0) ? 3 : last + 4); end
        last = cyc;
        n++;
      end
    end
    n_checks++; if (n !== 6) begin n_fail++; $display("FAIL rr_count got %0d want 6", n); end
    req_valid = '0;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_concurrent_add();
    logic [2:0]  pend;
    logic [15:0] erd, env;
    logic [7:0]  eer;
    logic [2:0]  oh;
    int elat, ewr, w, cyc, n;
    do_reset();
    poke(10'h020, 16'h0100);
    @(negedge clk);
    req_op = {2'd2, 2'd2, 2'd0};
    req_addr = {10'h020, 10'h020, 10'h000};
    req_wdata = {16'h0010, 16'h0010, 16'h0000};
    req_valid = 3'b110;
    pend = 3'b110; cyc = 0; n = 0;
    while (pend != 3'b000 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != 3'b000) begin
        w = pick(pend, mptr);
        oh = 3'b001 << w;
        model(2'd2, ref_mem[10'h020], 16'h0010, erd, eer, env, elat, ewr);
        ref_mem[10'h020] = env;
        n_checks++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL conc%0d_owner got %b want %b", n, rsp_valid, oh); end
        n_checks++; if (rsp_rdata !== erd || rsp_err !== eer) begin n_fail++; $display("FAIL conc%0d_result got %h/%h want %h/%h", n, rsp_rdata, rsp_err, erd, eer); end
        pend[w] = 1'b0;
        req_valid = req_valid & ~rsp_valid;
        mptr = (w + 1) % 3;
        n++;
      end
    end
    req_valid = '0;
    n_checks++; if (pend !== 3'b000) begin n_fail++; $display("FAIL conc_timeout got pending %b want 000", pend); end
    n_checks++; if (ram[10'h020] !== 16'h0120) begin n_fail++; $display("FAIL conc_final_memory got %h want 0120", ram[10'h020]); end
  endtask

  task automatic test_reset_mid_wb();
    int cyc, seen_rsp;
    logic [2:0] first;
    poke(10'h030, 16'h0500);
    @(negedge clk);
    req_op[5:4] = 2'd3; req_addr[29:20] = 10'h030; req_wdata[47:32] = 16'h0100;
    req_valid = 3'b100;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL rstwb_strobes got en=%b we=%b want 0 0", mem_en, mem_we); end
    n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL rstwb_rsp got %b want 000", rsp_valid); end
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0; mptr = 0;
    seen_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid != 3'b000 || busy) seen_rsp++;
    end
    n_checks++; if (seen_rsp !== 0) begin n_fail++; $display("FAIL rstwb_quiet got %0d active cycles want 0", seen_rsp); end
    n_checks++; if (ram[10'h030] !== 16'h0500) begin n_fail++; $display("FAIL rstwb_memory got %h want 0500", ram[10'h030]); end
    req_op = '0;
    req_addr = {10'h000, 10'h005, 10'h030};
    req_valid = 3'b011;
    first = '0; cyc = 0;
    while (req_valid != 3'b000 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != 3'b000) begin
        if (first == 3'b000) first = rsp_valid;
        req_valid = req_valid & ~rsp_valid;
      end
    end
    req_valid = '0;
    n_checks++; if (first !== 3'b001) begin n_fail++; $display("FAIL rstwb_ptr_first got %b want 001", first); end
    n_checks++; if (cyc >= 30) begin n_fail++; $display("FAIL rstwb_drain timeout got %0d cycles want <30", cyc); end
    mptr = 2;
  endtask

  task automatic test_random();
    logic [1:0]  r_op[3];
    logic [9:0]  r_addr[3];
    logic [15:0] r_wd[3];
    logic [2:0]  pend, oh;
    logic [15:0] erd, env, sm;
    logic [7:0]  eer;
    int elat, ewr, w, cyc;
    do_reset();
    for (int k = 0; k < 4; k++) poke(10'h3C0 + 10'(k), 16'($urandom));
    for (int round = 0; round < 30; round++) begin
      @(negedge clk);
      pend = 3'($urandom_range(1, 7));
      for (int r = 0; r < 3; r++) begin
        sm = 16'($urandom_range(0, 3));
        r_op[r] = 2'($urandom_range(0, 3));
        r_addr[r] = 10'h3C0 + 10'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: r_wd[r] = sm;
          1: r_wd[r] = 16'hFFFF - sm;
          default: r_wd[r] = 16'($urandom);
        endcase
        req_op[r*2 +: 2] = r_op[r];
        req_addr[r*10 +: 10] = r_addr[r];
        req_wdata[r*16 +: 16] = r_wd[r];
      end
      req_valid = pend;
      cyc = 0;
      while (pend != 3'b000 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (rsp_valid != 3'b000) begin
          w = pick(pend, mptr);
          oh = 3'b001 << w;
          model(r_op[w], ref_mem[r_addr[w]], r_wd[w], erd, eer, env, elat, ewr);
          ref_mem[r_addr[w]] = env;
          n_checks++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL rnd%0d_owner got %b want %b", round, rsp_valid, oh); end
          n_checks++; if (rsp_rdata !== erd || rsp_err !== eer) begin n_fail++; $display("FAIL rnd%0d_result got %h/%h want %h/%h", round, rsp_rdata, rsp_err, erd, eer); end
          pend[w] = 1'b0;
          req_valid = req_valid & ~rsp_valid;
          mptr = (w + 1) % 3;
        end
      end
      if (pend != 3'b000) begin
        n_checks++; n_fail++;
        $display("FAIL rnd%0d_timeout got pending %b want 000", round, pend);
        req_valid = '0;
        break;
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (ram[10'h3C0 + 10'(k)] !== ref_mem[10'h3C0 + 10'(k)]) begin n_fail++; $display("FAIL rnd%0d_memory[%0d] got %h want %h", round, k, ram[10'h3C0 + 10'(k)], ref_mem[10'h3C0 + 10'(k)]); end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    test_reset();
    test_single_ops();
    test_round_robin();
    test_concurrent_add();
    test_reset_mid_wb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
